// File: rtl/instr_encoder_writer.sv
// rtl/instr_encoder_writer.sv - encodes symbolic LEGv8 requests and streams them into instruction memory
module instr_encoder_writer #(
  parameter int DEPTH     = 4,
  parameter int AW        = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op_sel,
  input  logic [4:0]    rd,
  input  logic [4:0]    rn,
  input  logic [4:0]    rm,
  input  logic [18:0]   imm,
  input  logic          mem_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   word_count,
  output logic          err_invalid
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   fifo [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] addr;
  logic [31:0]   enc;
  logic          is_invalid;
  logic          full, empty, accept, push, pop;

  always_comb begin
    enc        = '0;
    is_invalid = 1'b0;
    case (op_sel)
      3'd0: enc = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      3'd1: enc = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      3'd2: enc = {8'b10110100, imm[18:0], rd};
      3'd3: enc = {11'b10001011000, rm, 6'b0, rn, rd};
      3'd4: enc = {11'b11001011000, rm, 6'b0, rn, rd};
      3'd5: enc = {11'b10001010000, rm, 6'b0, rn, rd};
      3'd6: enc = {11'b10101010000, rm, 6'b0, rn, rd};
      default: is_invalid = 1'b1;
    endcase
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign accept = in_valid && in_ready && !start;
  assign push   = accept && !is_invalid;
  assign pop    = !empty && !mem_stall && !start;

  assign mem_we    = pop;
  assign mem_addr  = addr;
  assign mem_wdata = empty ? 32'd0 : fifo[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= enc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      addr        <= AW'(BASE_ADDR);
      word_count  <= '0;
      err_invalid <= 1'b0;
    end else if (start) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      addr        <= AW'(BASE_ADDR);
      word_count  <= '0;
      err_invalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        addr   <= addr + 1'b1;
        if (word_count != '1) word_count <= word_count + (AW+1)'(1);
      end
      if (accept && is_invalid) err_invalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// tb/tb_instr_encoder_writer.sv - scoreboard bench for instr_encoder_writer
module tb_instr_encoder_writer;
  localparam int DEPTH = 4;
  localparam int AW    = 6;

  logic          clk = 0, reset = 0, start = 0, in_valid = 0, mem_stall = 0;
  logic [2:0]    op_sel = 0;
  logic [4:0]    rd = 0, rn = 0, rm = 0;
  logic [18:0]   imm = 0;
  logic          in_ready, mem_we, err_invalid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  int checks = 0, errors = 0;
  logic [31:0] exp_q [$];
  int exp_addr = 0, exp_cnt = 0;
  bit exp_err = 0;

  instr_encoder_writer #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .mem_stall(mem_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .err_invalid(err_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_enc(int unsigned op, int unsigned d, int unsigned n,
                                          int unsigned m, int unsigned im);
    int unsigned opc;
    case (op)
      0: return (32'h7C2 << 21) + ((im % 512) << 12) + (n << 5) + d;
      1: return (32'h7C0 << 21) + ((im % 512) << 12) + (n << 5) + d;
      2: return (32'hB4 << 24) + ((im % 524288) << 5) + d;
      default: begin
        opc = (op == 3) ? 32'h458 : (op == 4) ? 32'h658 : (op == 5) ? 32'h450 : 32'h550;
        return (opc << 21) + (m << 16) + (n << 5) + d;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      logic exp_we;
      chk("word_count", word_count, exp_cnt);
      chk("mem_addr", mem_addr, exp_addr);
      chk("err_invalid", err_invalid, exp_err);
      chk("in_ready", in_ready, exp_q.size() < DEPTH);
      exp_we = !start && !mem_stall && (exp_q.size() != 0);
      chk("mem_we", mem_we, exp_we);
      if (exp_q.size() == 0) chk("wdata_empty", mem_wdata, 0);
      if (mem_we && exp_q.size() != 0) begin
        chk("mem_wdata", mem_wdata, exp_q.pop_front());
        exp_addr = (exp_addr + 1) % (1 << AW);
        if (exp_cnt < (1 << (AW + 1)) - 1) exp_cnt++;
      end
    end
  end

  task automatic send(input int op, input int d, input int n, input int m, input int im,
                      input bit use_k, input logic [31:0] k);
    int t = 0;
    bit ok = 0;
    op_sel = 3'(op); rd = 5'(d); rn = 5'(n); rm = 5'(m); imm = 19'(im);
    in_valid = 1;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        if (op == 7) exp_err = 1;
        else exp_q.push_back(use_k ? k : ref_enc(op, d, n, m, im));
      end else if (++t > 40) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: in_ready stuck 0 expected 1");
        break;
      end
    end
    #1 in_valid = 0;
  endtask

  task automatic send_rand();
    send($urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 524287), 0, 0);
  endtask

  task automatic do_start(input bit with_req);
    start = 1;
    if (with_req) begin
      op_sel = 3'($urandom_range(0, 6)); rd = 5'($urandom); imm = 19'($urandom);
      in_valid = 1;
    end
    @(posedge clk);
    exp_q.delete(); exp_addr = 0; exp_cnt = 0; exp_err = 0;
    #1 start = 0; in_valid = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words left expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_err", err_invalid, 0);
    reset = 1;
    @(posedge clk); #1;

    do_start(0);
    send(3, 3, 1, 2, 0, 1, 32'h8B020023);
    wait_drain();
    chk("add_count", word_count, 1);

    do_start(0);
    send(0, 9, 22, 0, 64, 1, 32'hF84402C9);
    send(1, 1, 2, 0, 'h1F8, 1, 32'hF81F8041);
    send(2, 5, 0, 0, 3, 1, 32'hB4000065);
    wait_drain();

    repeat (20) send_rand();
    wait_drain();

    do_start(0);
    mem_stall = 1;
    fork
      begin repeat (5) send_rand(); end
      begin repeat (8) @(posedge clk); #1 mem_stall = 0; end
    join
    wait_drain();
    chk("stall_count", word_count, 5);

    do_start(0);
    repeat (65) send_rand();
    wait_drain();
    chk("wrap_count", word_count, 65);
    chk("wrap_addr", mem_addr, 1);

    send(7, 1, 1, 1, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("invalid_sticky", err_invalid, 1);

    mem_stall = 1;
    repeat (3) send_rand();
    do_start(1);
    mem_stall = 0;
    chk("start_addr", mem_addr, 0);
    chk("start_count", word_count, 0);
    chk("start_err", err_invalid, 0);
    chk("start_we", mem_we, 0);

    send_rand();
    mem_stall = 1;
    send(7, 0, 0, 0, 0, 0, 0);
    send_rand();
    send_rand();
    @(posedge clk);
    #3 reset = 0;
    exp_q.delete(); exp_addr = 0; exp_cnt = 0; exp_err = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_count", word_count, 0);
    chk("mid_rst_err", err_invalid, 0);
    @(posedge clk);
    #1 reset = 1; mem_stall = 0;

    repeat (6) send_rand();
    wait_drain();
    chk("final_count", word_count, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
